// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array sequencing controller.
package sa_pkg;

  localparam int unsigned SA_PERF_W  = 32;
  localparam logic        SA_MODE_WS = 1'b1;
  localparam logic        SA_MODE_OS = 1'b0;

  typedef enum logic [2:0] {
    SA_IDLE,
    SA_LOAD,
    SA_COMPUTE,
    SA_FLUSH,
    SA_DRAIN,
    SA_DRAIN_TAIL,
    SA_DONE
  } sa_state_t;

  function automatic int unsigned sa_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sa_phase_cnt.sv
// Loadable phase down-counter; tc_c flags the last cycle of the current phase.
module sa_phase_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc_c = (cnt == '0);

endmodule

// File: rtl/sa_ctrl.sv
// Systolic-array job sequencer driving load/feed/flush/drain phases for WS and OS jobs.
// Optional busy-cycle performance counter enabled by defining SA_CTRL_PERF_EN.
module sa_ctrl
  import sa_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  parameter int unsigned K_W  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           mode,
  input  logic [K_W-1:0] k_len,
  input  logic           abort,
  output logic           data_flow,
  output logic           load,
  output logic           drain,
  output logic           feed_en,
  output logic [K_W-1:0] feed_idx,
  output logic           busy,
  output logic           done
`ifdef SA_CTRL_PERF_EN
  ,output logic [SA_PERF_W-1:0] perf_cycles
`endif
);

  localparam int unsigned K_MAX = 2 ** K_W;
  localparam int unsigned CNT_W = $clog2(sa_max(K_MAX, ROWS + COLS));

  sa_state_t      state, next_state;
  logic [K_W-1:0] k_q;
  logic [K_W-1:0] k_sel;
  logic           accept;
  logic           tc_c;
  logic           cnt_load;
  logic [CNT_W-1:0] cnt_val;

  logic           data_flow_d, load_d, drain_d, feed_en_d, busy_d, done_d;
  logic [K_W-1:0] feed_idx_d;

  assign accept = (state == SA_IDLE) && start && !abort;
  // In IDLE the job's k_len is still on the input; afterwards use the captured copy.
  assign k_sel  = (state == SA_IDLE) ? k_len : k_q;

  sa_phase_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc_c     (tc_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SA_IDLE;
      k_q   <= '0;
    end else begin
      state <= next_state;
      if (accept) k_q <= k_len;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      SA_IDLE: if (accept) begin
        if (mode == SA_MODE_WS)  next_state = SA_LOAD;
        else if (k_len == '0)    next_state = SA_FLUSH;
        else                     next_state = SA_COMPUTE;
      end
      SA_LOAD:       if (tc_c) next_state = (k_q == '0) ? SA_FLUSH : SA_COMPUTE;
      SA_COMPUTE:    if (tc_c) next_state = SA_FLUSH;
      SA_FLUSH:      if (tc_c) next_state = (data_flow == SA_MODE_WS) ? SA_DONE : SA_DRAIN;
      SA_DRAIN:      if (tc_c) next_state = SA_DRAIN_TAIL;
      SA_DRAIN_TAIL: next_state = SA_DONE;
      SA_DONE:       next_state = SA_IDLE;
      default:       next_state = SA_IDLE;
    endcase
    if (abort && state != SA_IDLE) next_state = SA_IDLE;
  end

  // Output and phase-counter load logic, computed for the upcoming cycle
  always_comb begin
    cnt_load    = (next_state != state);
    cnt_val     = '0;
    data_flow_d = accept ? mode : data_flow;
    load_d      = (next_state == SA_LOAD);
    drain_d     = (next_state == SA_DRAIN);
    feed_en_d   = (next_state == SA_COMPUTE);
    busy_d      = (next_state != SA_IDLE);
    done_d      = (next_state == SA_DONE);
    feed_idx_d  = '0;
    unique case (next_state)
      SA_LOAD:    cnt_val = CNT_W'(ROWS - 1);
      SA_COMPUTE: cnt_val = CNT_W'(k_sel - K_W'(1));
      SA_FLUSH:   cnt_val = CNT_W'(ROWS + COLS - 1);
      SA_DRAIN:   cnt_val = CNT_W'(ROWS - 1);
      default:    cnt_val = '0;
    endcase
    if (next_state == SA_COMPUTE && state == SA_COMPUTE) feed_idx_d = feed_idx + K_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_flow <= 1'b0;
      load      <= 1'b0;
      drain     <= 1'b0;
      feed_en   <= 1'b0;
      feed_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      data_flow <= data_flow_d;
      load      <= load_d;
      drain     <= drain_d;
      feed_en   <= feed_en_d;
      feed_idx  <= feed_idx_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

`ifdef SA_CTRL_PERF_EN
  logic [SA_PERF_W-1:0] perf_cnt;
  logic [SA_PERF_W-1:0] perf_inc;

  assign perf_inc = (perf_cnt == '1) ? perf_cnt : perf_cnt + SA_PERF_W'(1);

  // perf_cnt holds completed busy cycles; the DONE cycle itself is added on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else begin
      if (accept)                  perf_cnt <= '0;
      else if (state != SA_IDLE)   perf_cnt <= perf_inc;
      if (state == SA_DONE && !abort) perf_cycles <= perf_inc;
    end
  end
`endif

endmodule

// File: tb/tb_sa_ctrl.sv
// Directed bench for sa_ctrl: OS/WS timelines, k_len=0, ignored start, abort and async reset.
module tb_sa_ctrl;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam int unsigned K_W  = 8;
  localparam int unsigned V_W  = K_W + 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           mode;
  logic [K_W-1:0] k_len;
  logic           abort;
  logic           data_flow, load, drain, feed_en, busy, done;
  logic [K_W-1:0] feed_idx;
`ifdef SA_CTRL_PERF_EN
  logic [31:0]    perf_cycles;
`endif
  logic [V_W-1:0] obs_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sa_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .k_len     (k_len),
    .abort     (abort),
    .data_flow (data_flow),
    .load      (load),
    .drain     (drain),
    .feed_en   (feed_en),
    .feed_idx  (feed_idx),
    .busy      (busy),
    .done      (done)
`ifdef SA_CTRL_PERF_EN
    ,.perf_cycles (perf_cycles)
`endif
  );

  assign obs_vec = {data_flow, load, drain, feed_en, busy, done, feed_idx};

  task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  // Expected output vector in cycle n after the accepting edge (cycle 1 = first busy cycle).
  function automatic logic [V_W-1:0] exp_vec(input bit ws, input int k, input int n);
    int c0, dr0, done_n;
    logic ld, dr, fe, bz, dn;
    logic [K_W-1:0] idx;
    c0     = ws ? ROWS + 1 : 1;
    dr0    = k + ROWS + COLS + 1;
    done_n = ws ? (ROWS + k + ROWS + COLS + 1) : (k + ROWS + COLS + ROWS + 2);
    ld  = ws && n >= 1 && n <= ROWS;
    fe  = n >= c0 && n < c0 + k;
    dr  = !ws && n >= dr0 && n < dr0 + ROWS;
    bz  = n >= 1 && n <= done_n;
    dn  = (n == done_n);
    idx = fe ? K_W'(n - c0) : '0;
    return {ws, ld, dr, fe, bz, dn, idx};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit ws, input int k);
    mode  = ws;
    k_len = K_W'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs a job for ncyc cycles; optional extra start (different mode/k) pulsed in cycle start_at.
  task automatic run_job(input string tag, input bit ws, input int k, input int ncyc, input int start_at);
    int dones = 0;
    issue(ws, k);
    for (int n = 1; n <= ncyc; n++) begin
      start = 1'b0;
      chk(tag, n, 32'(obs_vec), 32'(exp_vec(ws, k, n)));
      if (done) dones++;
      if (n == start_at) begin
        start = 1'b1;
        mode  = ~ws;
        k_len = K_W'(3);
      end
      tick();
    end
    start = 1'b0;
    chk({tag, "_done_count"}, ncyc, 32'(dones), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    k_len = '0;
    abort = 1'b0;
    #12;
    chk("reset_outputs", 0, 32'(obs_vec), 32'd0);
`ifdef SA_CTRL_PERF_EN
    chk("reset_perf", 0, perf_cycles, 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    tick();

    run_job("os_k8", 1'b0, 8, 24, 0);
`ifdef SA_CTRL_PERF_EN
    chk("perf_os_k8", 24, perf_cycles, 32'd22);
`endif

    run_job("ws_k8", 1'b1, 8, 23, 0);
`ifdef SA_CTRL_PERF_EN
    chk("perf_ws_k8", 23, perf_cycles, 32'd21);
`endif

    run_job("os_k0", 1'b0, 0, 16, 0);
`ifdef SA_CTRL_PERF_EN
    chk("perf_os_k0", 16, perf_cycles, 32'd14);
`endif

    run_job("os_start_busy", 1'b0, 8, 24, 5);
`ifdef SA_CTRL_PERF_EN
    chk("perf_start_busy", 24, perf_cycles, 32'd22);
`endif

    // Abort in cycle 18 (drain phase) of an OS job
    issue(1'b0, 8);
    for (int n = 1; n < 18; n++) tick();
    chk("abort_pre_drain", 18, 32'(drain), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", 19, 32'(obs_vec), 32'd0);
    for (int n = 20; n < 30; n++) begin
      chk("abort_no_done", n, 32'({busy, done}), 32'd0);
      tick();
    end
`ifdef SA_CTRL_PERF_EN
    chk("abort_perf_kept", 30, perf_cycles, 32'd22);
`endif
    run_job("ws_after_abort", 1'b1, 8, 23, 0);
`ifdef SA_CTRL_PERF_EN
    chk("perf_after_abort", 23, perf_cycles, 32'd21);
`endif

    // Asynchronous reset mid WS job, in cycle 10
    issue(1'b1, 8);
    for (int n = 1; n < 10; n++) tick();
    chk("ws_pre_reset", 10, 32'(feed_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 10, 32'(obs_vec), 32'd0);
`ifdef SA_CTRL_PERF_EN
    chk("async_reset_perf", 10, perf_cycles, 32'd0);
`endif
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_reset_idle", 0, 32'(obs_vec), 32'd0);
    run_job("ws_restart", 1'b1, 8, 23, 0);
`ifdef SA_CTRL_PERF_EN
    chk("perf_restart", 23, perf_cycles, 32'd21);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
